ram_port_master: RTL and testbench
==================================

Name: ram_port_master

Overview:
- Initiator for the on-chip byte-lane SRAM port: the single-cycle RAM with active-low per-lane chip selects and write enables, and one-cycle registered read data.
- Converts a valid/ready request (address, size, read/write, write data) into a correctly timed lane-select transaction.
- Returns aligned, extended read data and a completion pulse.
- Used by the boot loader copy engine and debug access path to drive the boot/main RAM without going through the core.

Parameters:
- ADDR_WIDTH, 12, byte-address width of the RAM; word address is [ADDR_WIDTH-1:2].

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request; high only in IDLE.
- req_addr  in  ADDR_WIDTH  byte address.
- req_we  in  1  1 = write, 0 = read.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend read data; ignored unless RAM_MASTER_SIGNEXT_EN is defined.
- req_wdata  in  32  write data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  read result, right-justified; 0 for writes and errors.
- rsp_err  out  1  valid with rsp_valid; misaligned or illegal size.
- mem_addr  out  ADDR_WIDTH-2  RAM word address.
- mem_cs_n  out  4  active-low lane selects; lane k = bits [8k+7:8k].
- mem_we_n  out  4  active-low lane write enables.
- mem_wdata  out  32  data to RAM.
- mem_rdata  in  32  data from RAM, valid the cycle after cs_n is low.

Behaviour:
- All outputs are registered.
- Reset values: req_ready=1 (state IDLE), rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0, mem_cs_n=4'hF, mem_we_n=4'hF, mem_wdata=0.
- Byte order is little-endian: byte offset k = req_addr[1:0] maps to lane k.
- Lane mask:
  - byte: 1<<k
  - half: 4'b0011 << k
  - word: 4'b1111
- Alignment rules:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Size 11 is always illegal.
- FSM states are IDLE, ACCESS, WAIT, RESP, ERR.
- IDLE:
  - req_ready=1.
  - On req_valid & legal: latch the request and go to ACCESS.
  - On req_valid & illegal: go to ERR.
- ACCESS (exactly one cycle):
  - mem_cs_n = ~mask; mem_addr = addr[ADDR_WIDTH-1:2].
  - Write: mem_we_n = ~mask; mem_wdata = byte replicated x4, half replicated x2, or word as-is. Next state RESP.
  - Read: mem_we_n = 4'hF. Next state WAIT.
- WAIT (read only):
  - mem_cs_n = 4'hF.
  - Capture mem_rdata, shift right by 8*k, mask to size, zero-extend.
  - Next state RESP.
- RESP: rsp_valid=1, rsp_err=0 for one cycle, then IDLE.
- ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0 for one cycle, then IDLE. The RAM is never selected.
- Latency, with the request accepted at edge N:
  - cs_n low in cycle N+1.
  - Write: rsp_valid in cycle N+2.
  - Read: rsp_valid in cycle N+3.
  - Error: rsp_valid in cycle N+1.
- req_ready is low from ACCESS through RESP/ERR. A held req_valid is accepted on the first IDLE cycle after RESP, so back-to-back throughput is one read per 4 cycles and one write per 3.
- mem_cs_n and mem_we_n are 4'hF in every state except ACCESS. Non-selected lanes are never enabled.
- mem_wdata, mem_addr and rsp_rdata hold their last values outside ACCESS and RESP.
- rsp_valid has no backpressure; the consumer must sample it.
- Reset asserted in any state (including ACCESS): next cycle state=IDLE, all outputs at reset values, no rsp_valid for the aborted request. A write aborted during ACCESS may or may not have been committed by the RAM at that edge.
- Request fields are ignored when req_valid=0 or req_ready=0.

Optional Feature:
- Macro: RAM_MASTER_SIGNEXT_EN.
- Defined: for reads with req_signed=1, byte/half results are sign-extended from bit 7/15. Word reads and writes are unaffected.
- Undefined: req_signed is ignored and all sub-word reads are zero-extended; the port still exists.

Test Plan:
- Word write addr 0x010, data 0xDEADBEEF, then word read 0x010 -> write: cs_n=0000, we_n=0000 for one cycle, rsp_valid at N+2. Read: rsp_rdata=0xDEADBEEF at N+3, rsp_err=0.
- Byte write 0xA5 to 0x013, then word read 0x010 -> write cycle shows cs_n=0111, we_n=0111, mem_wdata=0xA5A5A5A5. Read returns 0xA5ADBEEF.
- Half read 0x012 after the previous step -> rsp_rdata=0x0000A5AD. With RAM_MASTER_SIGNEXT_EN and req_signed=1 -> 0xFFFFA5AD.
- Word read at 0x006, and half read at 0x001 -> rsp_valid and rsp_err=1 at N+1, rsp_rdata=0, mem_cs_n stays 1111 throughout.
- req_valid held high for 3 reads -> accepts spaced 4 cycles apart, exactly 3 rsp_valid pulses, req_ready low between accepts.
- rst_n low during ACCESS of a read -> next cycle cs_n=1111, req_ready=1, no rsp_valid ever issued for that read.

Source files
------------

// File: rtl/ram_port_master.sv
// ram_port_master: valid/ready request to byte-lane SRAM transaction initiator with registered outputs.
// Define RAM_MASTER_SIGNEXT_EN to honour req_signed on byte/half reads.
module ram_port_master #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-3:0] mem_addr,
   output logic [3:0]            mem_cs_n,
   output logic [3:0]            mem_we_n,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);
   typedef enum logic [2:0] {IDLE, ACCESS, WAIT, RESP, ERR} state_t;
   state_t state_q, state_d;
   logic [1:0] off_q, off_d, size_q, size_d;
   logic we_q, we_d, sgn_q, sgn_d;
   logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d, mem_wdata_q, mem_wdata_d;
   logic [ADDR_WIDTH-3:0] mem_addr_q, mem_addr_d;
   logic [3:0] mem_cs_n_q, mem_cs_n_d, mem_we_n_q, mem_we_n_d;
   logic illegal;
   logic [3:0] mask;
   logic [31:0] wrep, shifted, rd;
   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_cs_n  = mem_cs_n_q;
   assign mem_we_n  = mem_we_n_q;
   assign mem_wdata = mem_wdata_q;
   assign illegal = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) |
                    (req_size == 2'b10 & |req_addr[1:0]);
   assign mask = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
                 req_size == 2'b01 ? 4'b0011 << req_addr[1:0] : 4'hF;
   assign wrep = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                 req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
   assign shifted = mem_rdata >> {off_q, 3'b000};
`ifdef RAM_MASTER_SIGNEXT_EN
   assign rd = size_q == 2'b00 ? {{24{sgn_q & shifted[7]}}, shifted[7:0]} :
               size_q == 2'b01 ? {{16{sgn_q & shifted[15]}}, shifted[15:0]} : shifted;
`else
   logic unused_sgn;
   assign unused_sgn = sgn_q;
   assign rd = size_q == 2'b00 ? {24'b0, shifted[7:0]} :
               size_q == 2'b01 ? {16'b0, shifted[15:0]} : shifted;
`endif
   always_comb begin
      state_d     = state_q;
      off_d       = off_q;
      size_d      = size_q;
      we_d        = we_q;
      sgn_d       = sgn_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_cs_n_d  = 4'hF;
      mem_we_n_d  = 4'hF;
      case (state_q)
         IDLE: if (req_valid) begin
            if (illegal) begin
               state_d     = ERR;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
            end else begin
               // Lane strobes are registered here so they appear exactly in ACCESS.
               state_d     = ACCESS;
               off_d       = req_addr[1:0];
               size_d      = req_size;
               we_d        = req_we;
               sgn_d       = req_signed;
               mem_addr_d  = req_addr[ADDR_WIDTH-1:2];
               mem_cs_n_d  = ~mask;
               mem_we_n_d  = req_we ? ~mask : 4'hF;
               mem_wdata_d = req_we ? wrep : mem_wdata_q;
            end
         end
         ACCESS: begin
            state_d     = we_q ? RESP : WAIT;
            rsp_valid_d = we_q;
            rsp_rdata_d = we_q ? 32'b0 : rsp_rdata_q;
         end
         WAIT: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rd;
         end
         default: state_d = IDLE;
      endcase
      req_ready_d = state_d == IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         off_q       <= '0;
         size_q      <= '0;
         we_q        <= 1'b0;
         sgn_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         mem_addr_q  <= '0;
         mem_cs_n_q  <= 4'hF;
         mem_we_n_q  <= 4'hF;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         size_q      <= size_d;
         we_q        <= we_d;
         sgn_q       <= sgn_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_cs_n_q  <= mem_cs_n_d;
         mem_we_n_q  <= mem_we_n_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end
endmodule

// File: tb/tb_ram_port_master.sv
// tb_ram_port_master: directed scoreboard bench for ram_port_master with a byte-lane RAM model.
module tb_ram_port_master;
   localparam int AW = 12;
   logic clk = 1'b0, rst_n = 1'b0;
   logic req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [1:0] req_size = 2'b00;
   logic [31:0] req_wdata = '0;
   logic req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
   logic [AW-3:0] mem_addr;
   logic [3:0] mem_cs_n, mem_we_n;
   logic [31:0] ram [1024];
   logic [32:0] sbq [$];
   int vectors = 0, fails = 0;

   ram_port_master #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_cs_n(mem_cs_n), .mem_we_n(mem_we_n),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int k = 0; k < 4; k++)
         if (!mem_cs_n[k] && !mem_we_n[k]) ram[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      if (mem_cs_n != 4'hF) mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic xact(input logic [AW-1:0] a, input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] wd, input logic err,
                       input logic [31:0] exp_rd, input logic [3:0] exp_cs,
                       input logic [31:0] exp_wd, input int exp_lat);
      int lat;
      logic [32:0] e;
      @(negedge clk);
      chk("ready_idle", req_ready, 1);
      req_valid = 1'b1; req_addr = a; req_we = we; req_size = sz; req_signed = sg; req_wdata = wd;
      sbq.push_back({err, exp_rd});
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      chk("cs_access", mem_cs_n, exp_cs);
      chk("we_access", mem_we_n, (we && !err) ? exp_cs : 4'hF);
      chk("ready_busy", req_ready, 0);
      if (!err) chk("addr_access", mem_addr, a[AW-1:2]);
      if (we && !err) chk("wdata_access", mem_wdata, exp_wd);
      while (!rsp_valid && lat < 8) begin
         @(negedge clk);
         lat++;
         chk("cs_idle", mem_cs_n, 4'hF);
      end
      chk("latency", lat, exp_lat);
      if (rsp_valid && sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("rsp_err", rsp_err, e[32]);
         chk("rsp_rdata", rsp_rdata, e[31:0]);
      end
   endtask

   initial begin
      int n, rsps, cnt;
      int acc [3];
      logic [32:0] e;
      repeat (3) @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_cs", mem_cs_n, 4'hF);
      chk("rst_we", mem_we_n, 4'hF);
      chk("rst_wdata", mem_wdata, 0);
      rst_n = 1'b1;
      xact(12'h010, 1, 2'b10, 0, 32'hDEADBEEF, 0, 32'h0, 4'h0, 32'hDEADBEEF, 2);
      xact(12'h010, 0, 2'b10, 0, 32'h0, 0, 32'hDEADBEEF, 4'h0, 32'h0, 3);
      xact(12'h013, 1, 2'b00, 0, 32'h000000A5, 0, 32'h0, 4'b0111, 32'hA5A5A5A5, 2);
      xact(12'h010, 0, 2'b10, 0, 32'h0, 0, 32'hA5ADBEEF, 4'h0, 32'h0, 3);
      xact(12'h012, 0, 2'b01, 0, 32'h0, 0, 32'h0000A5AD, 4'b0011, 32'h0, 3);
`ifdef RAM_MASTER_SIGNEXT_EN
      xact(12'h012, 0, 2'b01, 1, 32'h0, 0, 32'hFFFFA5AD, 4'b0011, 32'h0, 3);
      xact(12'h011, 0, 2'b00, 1, 32'h0, 0, 32'hFFFFFFBE, 4'b1101, 32'h0, 3);
`else
      xact(12'h012, 0, 2'b01, 1, 32'h0, 0, 32'h0000A5AD, 4'b0011, 32'h0, 3);
      xact(12'h011, 0, 2'b00, 1, 32'h0, 0, 32'h000000BE, 4'b1101, 32'h0, 3);
`endif
      xact(12'h016, 1, 2'b01, 0, 32'h00001234, 0, 32'h0, 4'b0011, 32'h12341234, 2);
      xact(12'h016, 0, 2'b01, 0, 32'h0, 0, 32'h00001234, 4'b0011, 32'h0, 3);
      xact(12'h006, 0, 2'b10, 0, 32'h0, 1, 32'h0, 4'hF, 32'h0, 1);
      xact(12'h001, 0, 2'b01, 0, 32'h0, 1, 32'h0, 4'hF, 32'h0, 1);
      xact(12'h000, 1, 2'b11, 0, 32'h55, 1, 32'h0, 4'hF, 32'h0, 1);
      // Held req_valid: three word reads accepted back to back.
      req_valid = 1'b1; req_addr = 12'h010; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      n = 0; rsps = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (n == 3) req_valid = 1'b0;
         if (rsp_valid) begin
            rsps++;
            e = (sbq.size() > 0) ? sbq.pop_front() : 33'h1_FFFF_FFFF;
            chk("b2b_rdata", rsp_rdata, e[31:0]);
            chk("b2b_err", rsp_err, e[32]);
         end
         if (req_valid && req_ready) begin
            acc[n] = c;
            n++;
            sbq.push_back({1'b0, 32'hA5ADBEEF});
         end
      end
      chk("b2b_accepts", n, 3);
      chk("b2b_rsps", rsps, 3);
      chk("b2b_gap1", acc[1] - acc[0], 4);
      chk("b2b_gap2", acc[2] - acc[1], 4);
      // Reset while a read is in ACCESS.
      @(negedge clk);
      req_valid = 1'b1; req_addr = 12'h010; req_size = 2'b10; req_we = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_cs_low", mem_cs_n, 4'h0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_cs", mem_cs_n, 4'hF);
      chk("abort_ready", req_ready, 1);
      chk("abort_rsp", rsp_valid, 0);
      rst_n = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) cnt++;
      end
      chk("abort_no_rsp", cnt, 0);
      xact(12'h010, 0, 2'b10, 0, 32'h0, 0, 32'hA5ADBEEF, 4'h0, 32'h0, 3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
